// File: rtl/sva_sysfunc_checker.sv
// Multi-channel run-time checker for antecedent |-> $rose/$fell/$stable/$changed.
// Each channel compares its sampled vector against the previous sample and reports pass/fail pulses.
module sva_sysfunc_checker #(
  parameter int N     = 4,
  parameter int DW    = 1,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [2*N-1:0]     mode,
  input  logic [N-1:0]       a,
  input  logic [N*DW-1:0]    b,
  output logic [N-1:0]       pass,
  output logic [N-1:0]       fail,
  output logic [N-1:0]       err_sticky,
  output logic [N*CNT_W-1:0] fail_cnt,
  output logic               any_fail
);

  localparam logic [1:0] MODE_ROSE    = 2'b00;
  localparam logic [1:0] MODE_FELL    = 2'b01;
  localparam logic [1:0] MODE_STABLE  = 2'b10;
  localparam logic [1:0] MODE_CHANGED = 2'b11;

  logic [N*DW-1:0] b_past;
  logic [N-1:0]    func_ok;
  logic [N-1:0]    fire;
  logic [N-1:0]    pass_nxt;
  logic [N-1:0]    fail_nxt;

  always_comb begin
    func_ok = '0;
    for (int i = 0; i < N; i++) begin
      case (mode[2*i +: 2])
        MODE_ROSE:    func_ok[i] = b[DW*i] & ~b_past[DW*i];
        MODE_FELL:    func_ok[i] = ~b[DW*i] & b_past[DW*i];
        MODE_STABLE:  func_ok[i] = (b[DW*i +: DW] == b_past[DW*i +: DW]);
        MODE_CHANGED: func_ok[i] = (b[DW*i +: DW] != b_past[DW*i +: DW]);
        default:      func_ok[i] = 1'b0;
      endcase
    end
  end

  assign fire     = {N{en}} & a;
  assign pass_nxt = fire & func_ok;
  assign fail_nxt = fire & ~func_ok;

  // History is tracked every cycle so a re-enabled check sees the latest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_past   <= '0;
      pass     <= '0;
      fail     <= '0;
      any_fail <= 1'b0;
    end else begin
      b_past   <= b;
      pass     <= pass_nxt;
      fail     <= fail_nxt;
      any_fail <= |fail_nxt;
    end
  end

  // Sticky/counter follow the registered fail pulse; clr drops history but keeps that pulse.
  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q         <= '0;
        err_sticky[g] <= 1'b0;
      end else if (clr) begin
        cnt_q         <= CNT_W'(fail[g]);
        err_sticky[g] <= fail[g];
      end else if (fail[g]) begin
        err_sticky[g] <= 1'b1;
        if (cnt_q != {CNT_W{1'b1}})
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign fail_cnt[CNT_W*g +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_sva_sysfunc_checker.sv
// Scoreboard bench for sva_sysfunc_checker: a behavioural model queues expected outputs per drive.
module tb_sva_sysfunc_checker;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [2*N-1:0]   mode;
  logic [N-1:0]     a;
  logic [N*DW-1:0]  b;
  logic [N-1:0]     pass;
  logic [N-1:0]     fail;
  logic [N-1:0]     err_sticky;
  logic [N*CNT_W-1:0] fail_cnt;
  logic             any_fail;

  sva_sysfunc_checker #(.N(N), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .a(a), .b(b),
    .pass(pass), .fail(fail), .err_sticky(err_sticky), .fail_cnt(fail_cnt),
    .any_fail(any_fail)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]       p;
    logic [N-1:0]       f;
    logic [N-1:0]       s;
    logic [N*CNT_W-1:0] c;
    logic               any;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]    m_past [N];
  logic             m_fail [N];
  logic             m_st   [N];
  logic [CNT_W-1:0] m_cnt  [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_past[i] = '0;
      m_fail[i] = 1'b0;
      m_st[i]   = 1'b0;
      m_cnt[i]  = '0;
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input logic e, input logic c, input logic [2*N-1:0] md,
                      input logic [N-1:0] aa, input logic [N*DW-1:0] bb);
    exp_t x;
    exp_t y;
    logic [DW-1:0] cur;
    logic ok;
    en = e; clr = c; mode = md; a = aa; b = bb;
    x = '0;
    for (int i = 0; i < N; i++) begin
      cur = bb[DW*i +: DW];
      case (md[2*i +: 2])
        2'b00:   ok = (cur[0] == 1'b1) && (m_past[i][0] == 1'b0);
        2'b01:   ok = (cur[0] == 1'b0) && (m_past[i][0] == 1'b1);
        2'b10:   ok = (cur == m_past[i]);
        default: ok = (cur != m_past[i]);
      endcase
      if (e && aa[i]) begin
        x.p[i] = ok;
        x.f[i] = !ok;
      end
      if (c) begin
        m_cnt[i] = m_fail[i] ? CNT_W'(1) : CNT_W'(0);
        m_st[i]  = m_fail[i];
      end else if (m_fail[i]) begin
        m_st[i] = 1'b1;
        if (m_cnt[i] != {CNT_W{1'b1}}) m_cnt[i] = m_cnt[i] + CNT_W'(1);
      end
      x.s[i] = m_st[i];
      x.c[CNT_W*i +: CNT_W] = m_cnt[i];
      m_fail[i] = x.f[i];
      m_past[i] = cur;
    end
    x.any = |x.f;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      y = sb.pop_front();
      chk("pass", 32'(pass), 32'(y.p));
      chk("fail", 32'(fail), 32'(y.f));
      chk("err_sticky", 32'(err_sticky), 32'(y.s));
      chk("fail_cnt", 32'(fail_cnt), 32'(y.c));
      chk("any_fail", 32'(any_fail), 32'(y.any));
    end
  endtask

  localparam logic [2*N-1:0] M_ROSE = 8'b00_00_00_00;
  localparam logic [2*N-1:0] M_FELL = 8'b01_01_01_01;
  localparam logic [2*N-1:0] M_STAB = 8'b10_10_10_10;
  localparam logic [2*N-1:0] M_CHG  = 8'b11_11_11_11;

  initial begin
    logic [DW-1:0] r;
    logic [DW-1:0] tog;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = '0; a = '0; b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_cnt", 32'(fail_cnt), 32'd0);
    chk("rst_any", 32'(any_fail), 32'd0);
    rst_n = 1'b1;

    // rose on channel 0, LSB only
    step(1, 0, M_ROSE, 4'b0000, 16'h0000);
    step(1, 0, M_ROSE, 4'b0001, 16'h0001);
    chk("rose_pass", 32'(pass[0]), 32'd1);
    step(1, 0, M_ROSE, 4'b0001, 16'h0001);
    chk("rose_fail", 32'(fail[0]), 32'd1);
    step(1, 0, M_ROSE, 4'b0000, 16'h0001);
    chk("rose_sticky", 32'(err_sticky[0]), 32'd1);
    chk("rose_cnt", 32'(fail_cnt[1:0]), 32'd1);

    // fell / changed on 4-bit vectors
    step(1, 0, M_FELL, 4'b0000, 16'h0003);
    step(1, 0, M_FELL, 4'b0001, 16'h0002);
    chk("fell_pass", 32'(pass[0]), 32'd1);
    step(1, 0, M_CHG, 4'b0000, 16'h0003);
    step(1, 0, M_CHG, 4'b0001, 16'h0002);
    chk("chg_pass", 32'(pass[0]), 32'd1);
    step(1, 0, M_CHG, 4'b0001, 16'h0002);
    chk("chg_fail", 32'(fail[0]), 32'd1);
    step(1, 0, M_FELL, 4'b0001, 16'h0003);
    chk("fell_fail", 32'(fail[0]), 32'd1);

    // vacuity, then disabled checks, then re-enable against last sample
    for (int k = 0; k < 5; k++) step(1, 0, M_STAB, 4'b0000, 16'(k[0] ? 16'hFFFF : 16'h0000));
    step(0, 0, M_STAB, 4'b1111, 16'h1111);
    step(0, 0, M_STAB, 4'b1111, 16'h2222);
    step(0, 0, M_STAB, 4'b1111, 16'h3333);
    step(1, 0, M_STAB, 4'b1111, 16'h3333);
    chk("reen_pass", 32'(pass), 32'hF);

    // saturation of the 2-bit counter and clr interaction
    step(1, 1, M_STAB, 4'b0000, 16'h0000);
    step(1, 1, M_STAB, 4'b0000, 16'h0000);
    for (int k = 0; k < 5; k++) step(1, 0, M_STAB, 4'b0001, 16'(k[0] ? 16'h0000 : 16'h0001));
    chk("sat_cnt", 32'(fail_cnt[1:0]), 32'd3);
    step(1, 1, M_STAB, 4'b0001, 16'h0001);
    chk("clrfail_cnt", 32'(fail_cnt[1:0]), 32'd1);
    chk("clrfail_sticky", 32'(err_sticky[0]), 32'd1);
    step(1, 0, M_STAB, 4'b0000, 16'h0001);
    step(1, 1, M_STAB, 4'b0000, 16'h0001);
    chk("clr_cnt", 32'(fail_cnt[1:0]), 32'd0);
    chk("clr_sticky", 32'(err_sticky[0]), 32'd0);

    // async reset mid-run with history present
    step(1, 0, M_STAB, 4'b0001, 16'h0000);
    step(1, 0, M_STAB, 4'b0001, 16'h0001);
    step(1, 0, M_STAB, 4'b0000, 16'h0001);
    chk("pre_rst_cnt", 32'(fail_cnt[1:0]), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sticky", 32'(err_sticky), 32'd0);
    chk("arst_cnt", 32'(fail_cnt), 32'd0);
    chk("arst_fail", 32'(fail), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    step(1, 0, M_ROSE, 4'b0001, 16'h0001);
    chk("post_rst_rose", 32'(pass[0]), 32'd1);

    // random multi-channel run, one function per channel, shared b
    for (int k = 0; k < 200; k++) begin
      r   = DW'($urandom_range(0, 15));
      tog = ($urandom_range(0, 3) == 0) ? r : DW'(m_past[0]);
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0), 8'b11_10_01_00,
           N'($urandom_range(0, 15)), {N{($urandom_range(0, 1) == 0) ? tog : r}});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
